// File: rtl/uart_tx_scheduler.sv
// Shares one uart_tx among NUM_REQ byte sources: 1-deep holding slot per port,
// fixed-priority launch (port 0 highest), tx_start sequenced against tx_busy.

module uart_tx_scheduler_slot #(
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr,
    output logic              full,
    output logic [DATA_W-1:0] data,
    output logic              accept,
    output logic              ovw
);
    // A post landing on the launch cycle refills the slot and is not an overwrite.
    assign ovw = wr & full & ~clr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            full   <= 1'b0;
            data   <= '0;
            accept <= 1'b0;
        end else begin
            accept <= wr;
            if (wr) begin
                full <= 1'b1;
                data <= wr_data;
            end else if (clr) begin
                full <= 1'b0;
            end
        end
    end
endmodule

module uart_tx_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 8,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_accept,
    output logic [NUM_REQ-1:0]          pending,
    output logic                        tx_start,
    output logic [DATA_W-1:0]           tx_data,
    input  logic                        tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        active,
    output logic [7:0]                  overwrite_cnt,
    output logic [7:0]                  timeout_cnt
);
    localparam int GID_W  = $clog2(NUM_REQ);
    localparam int TMO_W  = $clog2(BUSY_TIMEOUT + 1);
    localparam int OVW_SW = $clog2(NUM_REQ + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_ARMED,
        S_BUSY,
        S_GAP
    } state_t;

    state_t                           state;
    logic [TMO_W-1:0]                 tmo;
    logic [NUM_REQ-1:0][DATA_W-1:0]   slot_data;
    logic [NUM_REQ-1:0]               slot_clr;
    logic [NUM_REQ-1:0]               slot_ovw;
    logic [GID_W-1:0]                 pick;
    logic [DATA_W-1:0]                pick_data;
    logic [OVW_SW-1:0]                ovw_sum;
    logic [8:0]                       ovw_next;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
        uart_tx_scheduler_slot #(.DATA_W(DATA_W)) u_slot (
            .clock   (clock),
            .reset   (reset),
            .wr      (req_valid[i]),
            .wr_data (req_data[i*DATA_W +: DATA_W]),
            .clr     (slot_clr[i]),
            .full    (pending[i]),
            .data    (slot_data[i]),
            .accept  (req_accept[i]),
            .ovw     (slot_ovw[i])
        );
    end

    always_comb begin
        slot_clr = '0;
        if (state == S_LAUNCH)
            slot_clr[grant_id] = 1'b1;
    end

    always_comb begin
        pick = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (pending[i]) pick = GID_W'(i);
    end

    // A same-cycle repost on the chosen port replaces the slot, so launch the newer byte.
    assign pick_data = req_valid[pick] ? req_data[pick*DATA_W +: DATA_W] : slot_data[pick];

    always_comb begin
        ovw_sum = '0;
        for (int i = 0; i < NUM_REQ; i++)
            ovw_sum = ovw_sum + OVW_SW'(slot_ovw[i]);
    end

    assign ovw_next = {1'b0, overwrite_cnt} + 9'(ovw_sum);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            overwrite_cnt <= '0;
        else
            overwrite_cnt <= ovw_next[8] ? 8'hFF : ovw_next[7:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            grant_id    <= '0;
            active      <= 1'b0;
            tmo         <= '0;
            timeout_cnt <= '0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (|pending && !tx_busy) begin
                        state    <= S_LAUNCH;
                        tx_start <= 1'b1;
                        tx_data  <= pick_data;
                        grant_id <= pick;
                        active   <= 1'b1;
                    end
                end
                S_LAUNCH: begin
                    state <= S_ARMED;
                    tmo   <= '0;
                end
                S_ARMED: begin
                    if (tx_busy) begin
                        state <= S_BUSY;
                    end else if (tmo == TMO_W'(BUSY_TIMEOUT - 1)) begin
                        // Transmitter never acknowledged: drop the byte and move on.
                        state  <= S_IDLE;
                        active <= 1'b0;
                        if (timeout_cnt != 8'hFF)
                            timeout_cnt <= timeout_cnt + 8'd1;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                S_BUSY: begin
                    if (!tx_busy) state <= S_GAP;
                end
                S_GAP: begin
                    state  <= S_IDLE;
                    active <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    active <= 1'b0;
                end
            endcase
        end
    end
endmodule
